// File: rtl/fwd_scoreboard_unit_if.sv
// Handshake bundle for fwd_scoreboard_unit: ID-stage inputs, stall/EX outputs.
// master = pipeline control side, slave = scoreboard.
interface fwd_scoreboard_unit_if #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2
);
  localparam int SELW = $clog2(FWD_DEPTH+1);

  logic                      flush_i;
  logic                      id_valid_i;
  logic [NUM_SRC*REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0]         id_rd_i;
  logic                      id_regwrite_i;
  logic                      id_load_i;
  logic                      stall_o;
  logic                      ex_valid_o;
  logic [NUM_SRC*SELW-1:0]   ex_fwd_sel_o;
`ifdef FWD_SCOREBOARD_PERF_EN
  logic [31:0]               stall_cnt_o;
  logic [31:0]               fwd_cnt_o;
`endif

  modport master (
    output flush_i, id_valid_i, id_rs_i,
    output id_rd_i, id_regwrite_i, id_load_i,
`ifdef FWD_SCOREBOARD_PERF_EN
    input  stall_cnt_o, fwd_cnt_o,
`endif
    input  stall_o, ex_valid_o, ex_fwd_sel_o
  );

  modport slave (
    input  flush_i, id_valid_i, id_rs_i,
    input  id_rd_i, id_regwrite_i, id_load_i,
`ifdef FWD_SCOREBOARD_PERF_EN
    output stall_cnt_o, fwd_cnt_o,
`endif
    output stall_o, ex_valid_o, ex_fwd_sel_o
  );
endinterface

// File: rtl/fwd_scoreboard_unit.sv
// Operand-forwarding select + load-use stall unit with its own dest tracker.
// Ports: clk_i, rst_n_i (async low), bus (slave). Option: FWD_SCOREBOARD_PERF_EN.
module fwd_scoreboard_unit #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  fwd_scoreboard_unit_if.slave bus
);
  localparam int SELW = $clog2(FWD_DEPTH+1);

  logic [FWD_DEPTH-1:0]    r_v;
  logic [FWD_DEPTH-1:0]    r_wr;
  logic [FWD_DEPTH-1:0]    r_ld;
  logic [REG_AW-1:0]       r_rd [FWD_DEPTH];
  logic [NUM_SRC*SELW-1:0] r_sel;

  logic [NUM_SRC*SELW-1:0] w_sel;
  logic [NUM_SRC-1:0]      w_hz;
  logic                    w_stall;
  logic                    w_acc;

  // Scan oldest to youngest so the youngest producer overwrites.
  always_comb begin
    w_sel = '0;
    w_hz  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int j = FWD_DEPTH-1; j >= 0; j--) begin
        if (r_v[j] && r_wr[j] && (r_rd[j] != '0) &&
            (r_rd[j] == bus.id_rs_i[k*REG_AW +: REG_AW])) begin
          w_sel[k*SELW +: SELW] = SELW'(j+1);
          w_hz[k] = r_ld[j] && (j < LOAD_LAT);
        end
      end
    end
  end

  assign w_stall = bus.id_valid_i && !bus.flush_i && (|w_hz);
  assign w_acc   = bus.id_valid_i && !bus.flush_i && !(|w_hz);

  assign bus.stall_o      = w_stall;
  assign bus.ex_valid_o   = r_v[0];
  assign bus.ex_fwd_sel_o = r_sel;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_v   <= '0;
      r_wr  <= '0;
      r_ld  <= '0;
      r_sel <= '0;
      for (int j = 0; j < FWD_DEPTH; j++)
        r_rd[j] <= '0;
    end else begin
      for (int j = 1; j < FWD_DEPTH; j++) begin
        r_v[j]  <= r_v[j-1];
        r_wr[j] <= r_wr[j-1];
        r_ld[j] <= r_ld[j-1];
        r_rd[j] <= r_rd[j-1];
      end
      r_v[0]  <= w_acc;
      r_wr[0] <= bus.id_regwrite_i;
      r_ld[0] <= bus.id_load_i;
      r_rd[0] <= bus.id_rd_i;
      r_sel   <= w_acc ? w_sel : '0;
    end
  end

`ifdef FWD_SCOREBOARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_acc && (|w_sel) && (r_fwd_cnt != 32'hFFFF_FFFF))
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.fwd_cnt_o   = r_fwd_cnt;
`endif
endmodule
